// File: rtl/udp_tx_pkt_buf.sv
// Packs an application byte stream into 32-bit words for the UDP transmit engine,
// buffers them in a FIFO and launches a frame on a full packet or after an idle timeout.
module udp_tx_pkt_buf #(
    parameter int PKT_BYTES      = 1024,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 125000,
    parameter int IFG_CYCLES     = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din_valid,
    input  logic [7:0]      din,
    output logic            din_ready,
    output logic            tx_start_en,
    output logic [15:0]     tx_byte_num,
    output logic [31:0]     tx_data,
    input  logic            tx_req,
    input  logic            tx_done,
    output logic [ADDR_W:0] fifo_level,
    output logic            overflow,
    output logic            underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PKT_WORDS = (ADDR_W + 1)'(PKT_BYTES / 4);
    localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W + 1)'(DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_START,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   level_reg, level_next;
    logic [1:0]        byte_idx_reg;
    logic [23:0]       lanes;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [15:0]       byte_num_reg, byte_num_next;
    logic [31:0]       tx_data_reg;
    logic              din_ready_reg, din_ready_next;
    logic              overflow_reg, underflow_reg;

    logic        accept;
    logic        fifo_empty;
    logic        rd_en;
    logic        pack_wr;
    logic        flush_wr;
    logic        wr_en;
    logic [31:0] wr_word;
    logic        pending;
    logic        timeout;

    assign accept     = din_valid && din_ready_reg;
    assign fifo_empty = (level_reg == '0);
    assign rd_en      = tx_req && !fifo_empty;
    assign pack_wr    = accept && (byte_idx_reg == 2'd3);
    assign flush_wr   = (state_reg == ST_FLUSH) && (byte_idx_reg != 2'd0);
    assign wr_en      = pack_wr || flush_wr;
    assign pending    = (level_reg != '0) || (byte_idx_reg != 2'd0);
    assign timeout    = pending && (to_cnt_reg == TO_LAST);

    // Wire order: b1 b0 b3 b2 from MSB down; unwritten lanes are zero, giving flush padding for free.
    assign wr_word = flush_wr ? {lanes[15:8], lanes[7:0], 8'h00, lanes[23:16]}
                              : {lanes[15:8], lanes[7:0], din, lanes[23:16]};

    // Partial-word byte lanes b0..b2; b3 goes straight into the FIFO write.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (wr_en) begin
                    lane_reg <= '0;
                end else if (accept && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= din;
                end
            end
            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        byte_num_next = byte_num_reg;
        case (state_reg)
            ST_IDLE: begin
                if (level_reg >= PKT_WORDS) begin
                    byte_num_next = 16'({PKT_WORDS, 2'b00});
                    state_next    = ST_START;
                end else if (timeout) begin
                    if (byte_idx_reg != 2'd0) begin
                        state_next = ST_FLUSH;
                    end else begin
                        byte_num_next = 16'({level_reg, 2'b00});
                        state_next    = ST_START;
                    end
                end
            end
            ST_FLUSH: state_next = ST_IDLE;
            ST_START: state_next = ST_SEND;
            ST_SEND: begin
                if (tx_done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Around a flush the counter parks at its terminal value so the launch follows immediately.
    always_comb begin
        to_cnt_next = '0;
        if ((state_reg == ST_FLUSH) || (state_next == ST_FLUSH)) begin
            to_cnt_next = TO_LAST;
        end else if (accept) begin
            to_cnt_next = '0;
        end else if ((state_reg == ST_IDLE) && pending) begin
            to_cnt_next = (to_cnt_reg == TO_LAST) ? to_cnt_reg : to_cnt_reg + 1'b1;
        end
    end

    assign din_ready_next = (level_next != FULL_LVL) && (state_next != ST_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            byte_idx_reg  <= '0;
            to_cnt_reg    <= '0;
            gap_cnt_reg   <= '0;
            byte_num_reg  <= '0;
            din_ready_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            to_cnt_reg    <= to_cnt_next;
            byte_num_reg  <= byte_num_next;
            din_ready_reg <= din_ready_next;
            gap_cnt_reg   <= (state_reg == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (state_reg == ST_FLUSH) begin
                byte_idx_reg <= '0;
            end else if (accept) begin
                byte_idx_reg <= byte_idx_reg + 1'b1;
            end
            if (din_valid && !din_ready_reg) begin
                overflow_reg <= 1'b1;
            end
            if (tx_req && fifo_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_reg <= '0;
        end else if (rd_en) begin
            tx_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign din_ready   = din_ready_reg;
    assign tx_start_en = (state_reg == ST_START);
    assign tx_byte_num = byte_num_reg;
    assign tx_data     = tx_data_reg;
    assign fifo_level  = level_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// Scoreboard bench for udp_tx_pkt_buf: a byte driver packs expected words into a queue,
// an engine model launches on tx_start_en, pops words with tx_req and compares tx_data.
module tb_udp_tx_pkt_buf;

    localparam int ADDR_W = 10;
    localparam int TO     = 200;
    localparam int IFG    = 12;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic            clk;
    logic            rst_n;
    logic            din_valid;
    logic [7:0]      din;
    logic            din_ready;
    logic            tx_start_en;
    logic [15:0]     tx_byte_num;
    logic [31:0]     tx_data;
    logic            tx_req;
    logic            tx_done;
    logic [ADDR_W:0] fifo_level;
    logic            overflow;
    logic            underflow;

    logic eng_req;
    logic man_req;
    assign tx_req = eng_req | man_req;

    udp_tx_pkt_buf #(
        .PKT_BYTES(1024),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TO),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din_valid(din_valid),
        .din(din),
        .din_ready(din_ready),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .tx_done(tx_done),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          exp_frames[$];
    logic [7:0]  m_bytes[4];
    int          m_idx = 0;

    int          start_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          frame_pops = 0;
    int          last_bn = 0;
    logic [31:0] first_w = '0;
    logic [31:0] last_w = '0;
    logic [31:0] last_exp = '0;
    bit          hold_done = 0;
    bit          eng_waiting = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_bytes[m_idx] = b;
        m_idx++;
        if (m_idx == 4) begin
            exp_q.push_back({m_bytes[1], m_bytes[0], m_bytes[3], m_bytes[2]});
            m_idx = 0;
        end
    endtask

    task automatic model_flush();
        if (m_idx > 0) begin
            for (int k = m_idx; k < 4; k++) m_bytes[k] = 8'h00;
            exp_q.push_back({m_bytes[1], m_bytes[0], m_bytes[3], m_bytes[2]});
            m_idx = 0;
        end
    endtask

    // Offers bytes base+i one per cycle, holding each until accepted.
    task automatic send_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int   guard;
            logic acc;
            guard = 0;
            do begin
                @(negedge clk);
                din       = base + 8'(i);
                din_valid = 1'b1;
                acc       = din_ready;
                guard++;
            end while (!acc && guard < 5000);
            if (acc) model_byte(din);
            else chk("send_stall", {31'd0, acc}, 32'd1);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    // Engine model: one request every 4 cycles, data sampled 2 cycles after each request.
    initial begin
        int          n;
        bit          ok;
        logic [31:0] e;
        eng_req = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start_en) begin
                start_cnt++;
                frame_pops = 0;
                if (done_cnt > 0) chk("ifg_gap", {31'd0, ((cyc - done_cyc) >= IFG)}, 32'd1);
                last_bn = tx_byte_num;
                if (exp_frames.size() == 0) chk("frame_unexpected", exp_frames.size(), 1);
                else chk("byte_num", tx_byte_num, exp_frames.pop_front());
                n  = tx_byte_num / 4;
                ok = 1;
                for (int w = 0; w < n; w++) begin
                    @(negedge clk);
                    if (!rst_n) begin ok = 0; break; end
                    eng_req = 1'b1;
                    @(negedge clk);
                    eng_req = 1'b0;
                    if (!rst_n) begin ok = 0; break; end
                    @(negedge clk);
                    if (!rst_n) begin ok = 0; break; end
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", tx_data, e);
                        last_exp = e;
                    end
                    if (w == 0) first_w = tx_data;
                    last_w = tx_data;
                    frame_pops++;
                    @(negedge clk);
                    if (!rst_n) begin ok = 0; break; end
                end
                eng_req = 1'b0;
                if (ok) begin
                    eng_waiting = 1;
                    while (hold_done) @(negedge clk);
                    eng_waiting = 0;
                    if (rst_n) begin
                        chk("byte_num_hold", tx_byte_num, 32'(n * 4));
                        tx_done  = 1'b1;
                        done_cyc = cyc;
                        @(negedge clk);
                        tx_done = 1'b0;
                        done_cnt++;
                        $display("frame %0d bytes=%0d first=%08h last=%08h", start_cnt, n * 4, first_w, last_w);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int   d0;
        int   acc_cnt;
        int   rej_i;
        int   n;
        logic acc;

        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        man_req   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", tx_start_en, 0);
        chk("rst_bytenum", tx_byte_num, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", din_ready, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: one full 1024-byte packet
        exp_frames.push_back(1024);
        send_seq(1024, 8'h00);
        wait_done(1, 3000, "t1_done");
        chk("t1_first", first_w, 32'h01000302);
        chk("t1_last", last_w, 32'hFDFCFFFE);
        repeat (20) @(negedge clk);
        chk("t1_starts", start_cnt, 1);
        chk("t1_level", fifo_level, 0);

        // 2: short packet flushed by timeout
        exp_frames.push_back(8);
        send_seq(6, 8'hA0);
        model_flush();
        wait_done(2, TO + 300, "t2_done");
        chk("t2_bytes", last_bn, 8);
        chk("t2_first", first_w, 32'hA1A0A3A2);
        chk("t2_last", last_w, 32'hA5A40000);
        repeat (20) @(negedge clk);
        chk("t2_level", fifo_level, 0);

        // 3: fill the FIFO while the engine withholds tx_done
        hold_done = 1;
        exp_frames.push_back(1024);
        send_seq(1024, 8'h10);
        n = 0;
        while (!eng_waiting && n < 3000) begin @(negedge clk); n++; end
        chk("t3_wait_send", {31'd0, eng_waiting}, 1);
        chk("t3_ovf_pre", overflow, 0);
        acc_cnt = 0;
        rej_i   = -1;
        for (int i = 0; i < 4 * DEPTH + 8; i++) begin
            @(negedge clk);
            if (rej_i >= 0 && i == rej_i + 1) chk("t3_ovf_flag", overflow, 1);
            din       = 8'h55 + 8'(i);
            din_valid = 1'b1;
            acc       = din_ready;
            if (acc) begin
                model_byte(din);
                acc_cnt++;
            end else if (rej_i < 0) begin
                rej_i = i;
                chk("t3_full_level", fifo_level, DEPTH);
                chk("t3_accepted", acc_cnt, 4 * DEPTH);
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        chk("t3_total_acc", acc_cnt, 4 * DEPTH);
        repeat (4) exp_frames.push_back(1024);
        hold_done = 0;
        wait_done(7, 6000, "t3_done");
        repeat (20) @(negedge clk);
        chk("t3_level", fifo_level, 0);
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_unf", underflow, 0);

        // 4: 2100 bytes -> 1024, 1024, then 52 by timeout
        exp_frames.push_back(1024);
        exp_frames.push_back(1024);
        exp_frames.push_back(52);
        send_seq(2100, 8'h37);
        wait_done(10, 6000, "t4_done");
        chk("t4_last_bytes", last_bn, 52);
        repeat (20) @(negedge clk);
        chk("t4_level", fifo_level, 0);

        // 5: asynchronous reset in the middle of SEND
        d0 = start_cnt;
        exp_frames.push_back(1024);
        send_seq(1024, 8'h00);
        n = 0;
        while (!(start_cnt > d0 && frame_pops >= 40) && n < 3000) begin @(negedge clk); n++; end
        chk("t5_mid_send", {31'd0, (frame_pops >= 40)}, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_start", tx_start_en, 0);
        chk("t5_rst_bytenum", tx_byte_num, 0);
        chk("t5_rst_data", tx_data, 0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_ready", din_ready, 0);
        chk("t5_rst_ovf", overflow, 0);
        chk("t5_rst_unf", underflow, 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_frames.delete();
        m_idx = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        exp_frames.push_back(1024);
        send_seq(1024, 8'h00);
        wait_done(d0 + 1, 3000, "t5_done");
        chk("t5_first", first_w, 32'h01000302);
        repeat (30) @(negedge clk);

        // 6: request with an empty FIFO
        chk("t6_unf_pre", underflow, 0);
        @(negedge clk);
        man_req = 1'b1;
        @(negedge clk);
        man_req = 1'b0;
        @(negedge clk);
        chk("t6_unf", underflow, 1);
        chk("t6_data_hold", tx_data, last_exp);
        chk("t6_level", fifo_level, 0);
        chk("t6_sb_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
